byte_symbol_feeder: RTL and testbench
=====================================

BYTE_SYMBOL_FEEDER -- requirements
Module: byte_symbol_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of 32-bit words held in the word FIFO (power of two, >=2).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 rx_data  input  8  received UART byte, valid only while rx_data_ready=1.
REQ-005 rx_data_ready  input  1  one-cycle strobe; SHALL be treated as one byte per high cycle.
REQ-006 clear  input  1  debounced one-cycle pulse; flushes all state (REQ-020).
REQ-007 sym_out  output  2  encoded symbol to the convolutional decoder.
REQ-008 sym_valid  output  1  sym_out holds a valid symbol.
REQ-009 sym_ready  input  1  decoder accepts sym_out this cycle.
REQ-010 fifo_level  output  $clog2(FIFO_DEPTH)+1  number of words currently in the FIFO.
REQ-011 overflow  output  1  sticky; a completed word was dropped.

Function
REQ-012 Byte assembly: a 2-bit byte counter SHALL place byte k (k=0..3) of each group into word bits [8k+7:8k], byte 0 first (little-endian).
REQ-013 On the rx_data_ready cycle carrying byte 3, the word {rx_data, partial[23:0]} SHALL be pushed to the FIFO at that clock edge and the byte counter SHALL wrap to 0.
REQ-014 Push SHALL be accepted when FIFO not full, or when full and a pop occurs the same cycle; otherwise the word SHALL be discarded and overflow set to 1.
REQ-015 Serializer FSM states: IDLE, SHIFT; IDLE with FIFO non-empty SHALL pop one word into a 32-bit shift register, load symbol counter 0, and go to SHIFT.
REQ-016 In SHIFT, sym_valid SHALL be 1 and sym_out SHALL equal shift[1:0]; on sym_valid&&sym_ready the register SHALL shift right by 2 and the counter SHALL increment.
REQ-017 After the 16th accepted symbol, FSM SHALL return to IDLE (one idle cycle between words, even if FIFO non-empty).
REQ-018 While sym_valid=1 and sym_ready=0, sym_out SHALL remain stable; sym_valid SHALL never drop without a handshake, except on clear or reset.
REQ-019 Latency: 4th byte strobe at cycle N with FSM IDLE and FIFO empty SHALL give first sym_valid=1 at cycle N+2.
REQ-020 clear SHALL, at the next edge, zero the byte counter and partial word, empty the FIFO, force FSM to IDLE, drop sym_valid, and clear overflow; clear SHALL take priority over a simultaneous rx_data_ready (byte discarded).
REQ-021 fifo_level SHALL reflect pushes and pops registered at the same edge; simultaneous push and pop SHALL leave level unchanged.

Reset
REQ-022 With rst_n=0 at a clock edge: byte counter 0, partial word 0, FIFO pointers 0, fifo_level 0, FSM IDLE, sym_valid 0, sym_out 0, overflow 0.
REQ-023 Reset asserted mid-word or mid-serialization SHALL abandon all data with no further symbols emitted.
REQ-024 No output SHALL depend combinationally on rst_n.

Structure
REQ-025 A shared package SHALL hold the FSM state enum (IDLE, SHIFT), SYM_W=2, WORD_W=32, and SYMS_PER_WORD=16.
REQ-026 The word FIFO SHALL be a sub-module word_fifo (synchronous, registered level, full/empty flags); assembly and serializer logic SHALL live in byte_symbol_feeder.

Verification
REQ-027 Bytes 0x1B,0xE4,0x00,0xFF with sym_ready=1 -> symbols 3,2,1,0, 0,1,2,3, 0,0,0,0, 3,3,3,3; first sym_valid 2 cycles after 4th strobe.
REQ-028 Same word, sym_ready=0 for 5 cycles after first sym_valid -> sym_out held at 3, sym_valid held 1; sequence then resumes unchanged.
REQ-029 sym_ready=0, send FIFO_DEPTH+2 words (4 bytes each) -> fifo_level saturates at FIFO_DEPTH (serializer holds 1 word), overflow=1, surplus word dropped; release sym_ready -> exactly FIFO_DEPTH+1 words emitted.
REQ-030 Send 2 bytes, pulse clear in same cycle as 3rd byte, then send 0xAA,0x55,0x0F,0xF0 -> single word 0xF00F55AA emitted; overflow=0.
REQ-031 rst_n=0 for 1 cycle after 8th symbol of a word -> sym_valid=0 next cycle, fifo_level=0, no remaining symbols emitted.

Source files
------------

// File: rtl/byte_symbol_feeder_pkg.sv
// Shared types and widths for the byte-to-symbol feeder and its word FIFO.
package byte_symbol_feeder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SYM_W         = 2;
    localparam int WORD_W        = 32;
    localparam int SYMS_PER_WORD = 16;
    localparam int SYM_CNT_W     = $clog2(SYMS_PER_WORD);

endpackage

// File: rtl/byte_symbol_feeder_word_fifo.sv
// Synchronous word FIFO with registered level; the read port shows the head word
// combinationally so a pop and its data land on the same edge.
module word_fifo
    import byte_symbol_feeder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WORD_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_pushData,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_popData,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_level;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_doPop   = i_pop && !o_empty;
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign w_doPush  = i_push && (!o_full || w_doPop);
    assign o_popData = r_mem[r_rdPtr];
    assign o_level   = r_level;

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/byte_symbol_feeder.sv
// Packs UART bytes little-endian into 32-bit words, buffers them, and streams
// each word out LSB-first as 2-bit symbols under a valid/ready handshake.
module byte_symbol_feeder
    import byte_symbol_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_data_ready,
    input  logic                        clear,
    output logic [SYM_W-1:0]            sym_out,
    output logic                        sym_valid,
    input  logic                        sym_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam logic [SYM_CNT_W-1:0] LAST_SYM = SYM_CNT_W'(SYMS_PER_WORD - 1);

    logic [1:0]           r_byteCnt;
    logic [WORD_W-9:0]    r_partial;
    logic                 r_overflow;
    ser_state_t           r_state;
    logic [WORD_W-1:0]    r_shift;
    logic [SYM_CNT_W-1:0] r_symCnt;

    ser_state_t           w_stateNext;
    logic [WORD_W-1:0]    w_shiftNext;
    logic [SYM_CNT_W-1:0] w_symCntNext;
    logic [WORD_W-1:0]    w_word;
    logic [WORD_W-1:0]    w_fifoData;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_fifoFull;
    logic                 w_fifoEmpty;

    assign w_word = {rx_data, r_partial};
    assign w_push = rx_data_ready && !clear && (r_byteCnt == 2'd3);
    assign w_drop = w_push && w_fifoFull && !w_pop;

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (clear),
        .i_push     (w_push),
        .i_pushData (w_word),
        .i_pop      (w_pop),
        .o_popData  (w_fifoData),
        .o_level    (fifo_level),
        .o_full     (w_fifoFull),
        .o_empty    (w_fifoEmpty)
    );

    // Byte 3 never lands in r_partial; it goes straight into the pushed word.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_byteCnt <= '0;
            r_partial <= '0;
        end else if (rx_data_ready) begin
            r_byteCnt <= r_byteCnt + 2'd1;
            case (r_byteCnt)
                2'd0:    r_partial[7:0]   <= rx_data;
                2'd1:    r_partial[15:8]  <= rx_data;
                2'd2:    r_partial[23:16] <= rx_data;
                default: r_partial        <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_symCnt <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_shift  <= w_shiftNext;
            r_symCnt <= w_symCntNext;
        end
    end

    // IDLE always lasts one cycle, giving a gap between back-to-back words.
    always_comb begin
        w_stateNext  = r_state;
        w_shiftNext  = r_shift;
        w_symCntNext = r_symCnt;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifoEmpty) begin
                    w_pop        = 1'b1;
                    w_shiftNext  = w_fifoData;
                    w_symCntNext = '0;
                    w_stateNext  = SHIFT;
                end
            end
            SHIFT: begin
                if (sym_ready) begin
                    w_shiftNext  = r_shift >> SYM_W;
                    w_symCntNext = r_symCnt + 1'b1;
                    if (r_symCnt == LAST_SYM) begin
                        w_stateNext = IDLE;
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
        if (clear) begin
            w_stateNext  = IDLE;
            w_shiftNext  = '0;
            w_symCntNext = '0;
            w_pop        = 1'b0;
        end
    end

    assign sym_valid = (r_state == SHIFT);
    assign sym_out   = r_shift[SYM_W-1:0];
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_byte_symbol_feeder.sv
// Directed bench for byte_symbol_feeder; a symbol scoreboard is filled when words
// are sent and drained by a monitor on every accepted handshake.
module tb_byte_symbol_feeder;
    import byte_symbol_feeder_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_data_ready;
    logic          clear;
    logic [1:0]    sym_out;
    logic          sym_valid;
    logic          sym_ready;
    logic [LW-1:0] fifo_level;
    logic          overflow;

    int         errors   = 0;
    int         checks   = 0;
    int         symCount = 0;
    logic [1:0] expQ[$];

    always #5 clk = ~clk;

    byte_symbol_feeder #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .clear         (clear),
        .sym_out       (sym_out),
        .sym_valid     (sym_valid),
        .sym_ready     (sym_ready),
        .fifo_level    (fifo_level),
        .overflow      (overflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic queueSyms(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            expQ.push_back(w[2*i +: 2]);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rx_data       = b;
        rx_data_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_data_ready = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(w[8*k +: 8]);
        end
    endtask

    task automatic waitDrain(input string tag, input int maxCycles);
        int n = 0;
        while ((expQ.size() != 0 || sym_valid) && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_drain"}, 32'(expQ.size()), 32'd0);
    endtask

    // Accepted symbols are scored mid-cycle, once the handshake inputs are settled.
    always @(negedge clk) begin
        if (rst_n && sym_valid && sym_ready) begin
            symCount++;
            checks++;
            assert (expQ.size() != 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_sym: observed=%0h expected=none", sym_out);
            end
            if (expQ.size() != 0) begin
                checkOutput("sym", 32'(sym_out), 32'(expQ.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int          base;
        logic [31:0] w;

        rst_n         = 1'b0;
        rx_data       = 8'h00;
        rx_data_ready = 1'b0;
        clear         = 1'b0;
        sym_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(sym_valid), 32'd0);
        checkOutput("rst_sym", 32'(sym_out), 32'd0);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic word and latency");
        base = symCount;
        queueSyms(32'hFF00E41B, 16);
        sendWord(32'hFF00E41B);
        checkOutput("t1_valid_n1", 32'(sym_valid), 32'd0);
        checkOutput("t1_level_n1", 32'(fifo_level), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("t1_valid_n2", 32'(sym_valid), 32'd1);
        checkOutput("t1_first_sym", 32'(sym_out), 32'd3);
        waitDrain("t1", 100);
        checkOutput("t1_count", 32'(symCount - base), 32'd16);

        $display("[TB] backpressure hold");
        base = symCount;
        queueSyms(32'hFF00E41B, 16);
        sendWord(32'hFF00E41B);
        sym_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_hold_valid", 32'(sym_valid), 32'd1);
            checkOutput("t2_hold_sym", 32'(sym_out), 32'd3);
            @(posedge clk);
            #1;
        end
        sym_ready = 1'b1;
        waitDrain("t2", 100);
        checkOutput("t2_count", 32'(symCount - base), 32'd16);

        $display("[TB] fifo saturation");
        base      = symCount;
        sym_ready = 1'b0;
        for (int k = 0; k < FIFO_DEPTH + 2; k++) begin
            w = 32'h13579BDF ^ (32'(k) * 32'h11111111);
            if (k < FIFO_DEPTH + 1) begin
                queueSyms(w, 16);
            end
            sendWord(w);
            if (k == FIFO_DEPTH) begin
                checkOutput("t3_level_full", 32'(fifo_level), 32'(FIFO_DEPTH));
                checkOutput("t3_no_overflow_yet", 32'(overflow), 32'd0);
            end
        end
        checkOutput("t3_level_sat", 32'(fifo_level), 32'(FIFO_DEPTH));
        checkOutput("t3_overflow", 32'(overflow), 32'd1);
        sym_ready = 1'b1;
        waitDrain("t3", 600);
        checkOutput("t3_count", 32'(symCount - base), 32'(16 * (FIFO_DEPTH + 1)));
        checkOutput("t3_overflow_sticky", 32'(overflow), 32'd1);

        $display("[TB] clear mid-word");
        base = symCount;
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        rx_data       = 8'h03;
        rx_data_ready = 1'b1;
        clear         = 1'b1;
        @(posedge clk);
        #1;
        rx_data_ready = 1'b0;
        clear         = 1'b0;
        checkOutput("t4_clr_overflow", 32'(overflow), 32'd0);
        checkOutput("t4_clr_level", 32'(fifo_level), 32'd0);
        queueSyms(32'hF00F55AA, 16);
        sendWord(32'hF00F55AA);
        waitDrain("t4", 100);
        checkOutput("t4_count", 32'(symCount - base), 32'd16);
        checkOutput("t4_overflow", 32'(overflow), 32'd0);

        $display("[TB] reset mid-serialization");
        base = symCount;
        queueSyms(32'hC3A55A3C, 8);
        sendWord(32'hC3A55A3C);
        @(posedge clk);
        #1;
        checkOutput("t5_valid", 32'(sym_valid), 32'd1);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b0;
        sym_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5_rst_valid", 32'(sym_valid), 32'd0);
        checkOutput("t5_rst_level", 32'(fifo_level), 32'd0);
        checkOutput("t5_rst_sym", 32'(sym_out), 32'd0);
        rst_n     = 1'b1;
        sym_ready = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        checkOutput("t5_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("t5_count", 32'(symCount - base), 32'd8);
        checkOutput("t5_idle_valid", 32'(sym_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
